// File: rtl/regfile_write_arbiter_if.sv
// Writeback request/ack bundle between the ALU/load units
// and the register file write arbiter.
interface regfile_write_arbiter_if;
  logic        ReqA;
  logic [1:0]  RdA;
  logic [15:0] DataA;
  logic        AckA;
  logic        ReqB;
  logic [1:0]  RdB;
  logic [15:0] DataB;
  logic        AckB;
  logic [1:0]  RD;
  logic [15:0] WriteData;
  logic        RegWrite;
  logic [3:0]  Pending;
  logic        Busy;

  modport master (
    output ReqA, RdA, DataA,
    output ReqB, RdB, DataB,
    input  AckA, AckB,
    input  RD, WriteData, RegWrite,
    input  Pending, Busy
  );

  modport slave (
    input  ReqA, RdA, DataA,
    input  ReqB, RdB, DataB,
    output AckA, AckB,
    output RD, WriteData, RegWrite,
    output Pending, Busy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester register file write arbiter: one holding
// buffer per requester, one register write per cycle.
module regfile_write_arbiter (
  input logic Clock,
  input logic Reset,
  regfile_write_arbiter_if.slave bus
);
  typedef struct packed {
    logic        full;
    logic [1:0]  rd;
    logic [15:0] data;
  } entry_t;

  entry_t      bufA;
  entry_t      bufB;
  logic        olderA;
  logic        rrA;
  logic        selA;
  logic        selB;
  logic        both;
  logic        keepA;
  logic        keepB;
  logic [1:0]  rdQ;
  logic [15:0] dataQ;
  logic        wrQ;
  logic [3:0]  pend;

  always_comb begin
    both  = bufA.full && bufB.full;
    selA  = 1'b0;
    if (bufA.full) begin
      if (!bufB.full)
        selA = 1'b1;
      else if (bufA.rd == bufB.rd)
        selA = olderA;
      else
        selA = rrA;
    end
    selB  = bufB.full && !selA;
    keepA = bufA.full && !selA;
    keepB = bufB.full && !selB;
  end

  assign bus.AckA = bus.ReqA && !Reset &&
                    (!bufA.full || selA);
  assign bus.AckB = bus.ReqB && !Reset &&
                    (!bufB.full || selB);

  always_comb begin
    pend = '0;
    if (!Reset) begin
      if (bufA.full) pend[bufA.rd] = 1'b1;
      if (bufB.full) pend[bufB.rd] = 1'b1;
    end
  end

  assign bus.Pending   = pend;
  assign bus.Busy      = !Reset && (bufA.full || bufB.full);
  assign bus.RD        = rdQ;
  assign bus.WriteData = dataQ;
  assign bus.RegWrite  = wrQ;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      bufA.full <= 1'b0;
      bufB.full <= 1'b0;
      rdQ       <= '0;
      dataQ     <= '0;
      wrQ       <= 1'b0;
      rrA       <= 1'b1;
      olderA    <= 1'b1;
    end else begin
      wrQ <= selA || selB;
      if (selA) begin
        rdQ   <= bufA.rd;
        dataQ <= bufA.data;
      end else if (selB) begin
        rdQ   <= bufB.rd;
        dataQ <= bufB.data;
      end
      if (both)
        rrA <= selB;
      if (selA) bufA.full <= 1'b0;
      if (selB) bufB.full <= 1'b0;
      if (bus.AckA)
        bufA <= '{1'b1, bus.RdA, bus.DataA};
      if (bus.AckB)
        bufB <= '{1'b1, bus.RdB, bus.DataB};
      // The entry left waiting is always the older one.
      if (bus.AckA && bus.AckB)
        olderA <= 1'b1;
      else if (bus.AckA && keepB)
        olderA <= 1'b0;
      else if (bus.AckB && keepA)
        olderA <= 1'b1;
    end
  end
endmodule
